// File: rtl/flash_prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : flash_prog_seq
// Brief    : Parallel-NOR byte-program / sector-erase command sequencer with
//            DQ7 data polling, DQ5 retry and poll-count timeout.
// Revision : 1.0
// ============================================================================
module flash_prog_seq #(
    parameter int unsigned WE_CYCLES  = 2,
    parameter logic [15:0] POLL_LIMIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [18:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [18:0] f_addr,
    output logic [7:0]  f_dout,
    input  logic [7:0]  f_din,
    output logic        f_ce_n,
    output logic        f_oe_n,
    output logic        f_we_n
);

    localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_PULSE = 3'd2,
        W_HOLD  = 3'd3,
        P_READ  = 3'd4,
        P_CHECK = 3'd5,
        FINISH  = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [3:0]  we_cnt_q, we_cnt_d;
    logic        rd_ph_q, rd_ph_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        retry_q, retry_d;
    logic        error_q, error_d;
    logic        op_q, op_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        dq7_q, dq7_d;
    logic        dq5_q, dq5_d;

    logic [18:0] seq_addr;
    logic [7:0]  seq_data;
    logic [2:0]  last_step;
    logic        poll_hit;
    logic        unused_din;

    assign unused_din = ^{f_din[6], f_din[4:0]};
    assign last_step  = op_q ? 3'd5 : 3'd3;
    assign poll_hit   = (dq7_q == (op_q ? 1'b1 : wdata_q[7]));
    assign error      = error_q;

    // Unlock / command table indexed by step
    always_comb begin
        seq_addr = 19'h00555;
        seq_data = 8'hAA;
        case (step_q)
            3'd1: begin seq_addr = 19'h002AA; seq_data = 8'h55; end
            3'd2: begin seq_addr = 19'h00555; seq_data = op_q ? 8'h80 : 8'hA0; end
            3'd3: begin
                if (!op_q) begin
                    seq_addr = addr_q;
                    seq_data = wdata_q;
                end
            end
            3'd4: begin seq_addr = 19'h002AA; seq_data = 8'h55; end
            3'd5: begin seq_addr = addr_q; seq_data = 8'h30; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        we_cnt_d   = we_cnt_q;
        rd_ph_d    = rd_ph_q;
        poll_cnt_d = poll_cnt_q;
        retry_d    = retry_q;
        error_d    = error_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        dq7_d      = dq7_q;
        dq5_d      = dq5_q;
        busy       = 1'b0;
        done       = 1'b0;
        f_ce_n     = 1'b1;
        f_oe_n     = 1'b1;
        f_we_n     = 1'b1;
        f_addr     = '0;
        f_dout     = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    error_d    = 1'b0;
                    step_d     = 3'd0;
                    poll_cnt_d = '0;
                    retry_d    = 1'b0;
                    state_d    = W_SETUP;
                end
            end
            W_SETUP: begin
                busy     = 1'b1;
                f_ce_n   = 1'b0;
                f_addr   = seq_addr;
                f_dout   = seq_data;
                we_cnt_d = '0;
                state_d  = W_PULSE;
            end
            W_PULSE: begin
                busy   = 1'b1;
                f_ce_n = 1'b0;
                f_we_n = 1'b0;
                f_addr = seq_addr;
                f_dout = seq_data;
                if (we_cnt_q == WE_LAST) begin
                    state_d = W_HOLD;
                end else begin
                    we_cnt_d = we_cnt_q + 4'd1;
                end
            end
            W_HOLD: begin
                busy   = 1'b1;
                f_ce_n = 1'b0;
                f_addr = seq_addr;
                f_dout = seq_data;
                if (step_q == last_step) begin
                    rd_ph_d = 1'b0;
                    state_d = P_READ;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = W_SETUP;
                end
            end
            P_READ: begin
                busy   = 1'b1;
                f_ce_n = 1'b0;
                f_oe_n = 1'b0;
                f_addr = addr_q;
                if (rd_ph_q) begin
                    dq7_d   = f_din[7];
                    dq5_d   = f_din[5];
                    rd_ph_d = 1'b0;
                    state_d = P_CHECK;
                end else begin
                    rd_ph_d = 1'b1;
                end
            end
            P_CHECK: begin
                busy       = 1'b1;
                f_ce_n     = 1'b0;
                f_addr     = addr_q;
                poll_cnt_d = poll_cnt_q + 16'd1;
                // A DQ5 miss earns exactly one confirmation poll before failing
                if (poll_hit) begin
                    state_d = FINISH;
                end else if (retry_q || (poll_cnt_d == POLL_LIMIT)) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else begin
                    if (dq5_q) begin
                        retry_d = 1'b1;
                    end
                    state_d = P_READ;
                end
            end
            FINISH: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            step_q     <= '0;
            we_cnt_q   <= '0;
            rd_ph_q    <= 1'b0;
            poll_cnt_q <= '0;
            retry_q    <= 1'b0;
            error_q    <= 1'b0;
            op_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            dq7_q      <= 1'b0;
            dq5_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            we_cnt_q   <= we_cnt_d;
            rd_ph_q    <= rd_ph_d;
            poll_cnt_q <= poll_cnt_d;
            retry_q    <= retry_d;
            error_q    <= error_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            dq7_q      <= dq7_d;
            dq5_q      <= dq5_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_flash_prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_flash_prog_seq
// Brief    : Self-checking bench for flash_prog_seq: cycle timeline model,
//            flash status model and bus monitor.
// Revision : 1.0
// ============================================================================
module tb_flash_prog_seq;

    localparam int          WE       = 2;
    localparam int          POLL_LIM = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [18:0] f_addr;
    logic [7:0]  f_dout;
    logic [7:0]  f_din;
    logic        f_ce_n;
    logic        f_oe_n;
    logic        f_we_n;

    flash_prog_seq #(
        .WE_CYCLES (WE),
        .POLL_LIMIT(16'(POLL_LIM))
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .op     (op),
        .addr   (addr),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .f_addr (f_addr),
        .f_dout (f_dout),
        .f_din  (f_din),
        .f_ce_n (f_ce_n),
        .f_oe_n (f_oe_n),
        .f_we_n (f_we_n)
    );

    always begin
        clk = 1'b0;
        #5;
        clk = 1'b1;
        #5;
    end

    typedef struct {
        logic        busy, done, ce_n, oe_n, we_n, err;
        logic [18:0] ad;
        logic [7:0]  dt;
        bit          c_ce, c_ad, c_dt;
    } exp_t;

    exp_t        exp_q[$];
    logic        exp_err = 1'b0;
    int          checks  = 0;
    int          errors  = 0;
    int          tcyc    = 0;
    string       cur_name = "reset";

    logic [7:0]  resp [8];
    int          nresp     = 1;
    int          poll_base = 0;
    int          wr_base   = 0;
    int          pidx;

    // Bus monitor: completed write cycles and completed status reads
    logic [31:0] wr_q[$];
    int          npolls  = 0;
    logic        prev_we = 1'b1;
    logic        prev_oe = 1'b1;

    always @(negedge clk) begin
        if (prev_we == 1'b0 && f_we_n == 1'b1) wr_q.push_back({5'd0, f_addr, f_dout});
        if (prev_oe == 1'b0 && f_oe_n == 1'b1) npolls <= npolls + 1;
        prev_we <= f_we_n;
        prev_oe <= f_oe_n;
    end

    // Flash status model: the n-th poll of a transaction returns resp[n]
    always_comb begin
        pidx = npolls - poll_base;
        if (pidx > nresp - 1) pidx = nresp - 1;
        if (pidx < 0) pidx = 0;
        f_din = resp[pidx];
    end

    function automatic exp_t mk(input logic b, input logic dn, input logic ce, input logic oe,
                                input logic we, input logic er, input logic [18:0] a,
                                input logic [7:0] d, input bit cce, input bit cad, input bit cdt);
        exp_t r;
        r.busy = b;  r.done = dn; r.ce_n = ce; r.oe_n = oe; r.we_n = we; r.err = er;
        r.ad = a;    r.dt = d;    r.c_ce = cce; r.c_ad = cad; r.c_dt = cdt;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Expected per-cycle timeline of one transaction, starting with the cycle after the accept edge
    task automatic build(input logic o, input logic [18:0] a, input logic [7:0] d, output int len);
        logic [18:0] wa [6];
        logic [7:0]  wd [6];
        int          nw;
        logic        tgt;
        logic        fail;
        bit          retry;
        logic [7:0]  dq;
        if (o) begin
            wa = '{19'h555, 19'h2AA, 19'h555, 19'h555, 19'h2AA, a};
            wd = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30};
            nw = 6;
            tgt = 1'b1;
        end else begin
            wa = '{19'h555, 19'h2AA, 19'h555, a, 19'h0, 19'h0};
            wd = '{8'hAA, 8'h55, 8'hA0, d, 8'h00, 8'h00};
            nw = 4;
            tgt = d[7];
        end
        for (int w = 0; w < nw; w++) begin
            exp_q.push_back(mk(1, 0, 0, 1, 1, 0, wa[w], wd[w], 1, 1, 1));
            for (int p = 0; p < WE; p++) exp_q.push_back(mk(1, 0, 0, 1, 0, 0, wa[w], wd[w], 1, 1, 1));
            exp_q.push_back(mk(1, 0, 0, 1, 1, 0, wa[w], wd[w], 1, 1, 1));
        end
        retry = 1'b0;
        fail  = 1'b0;
        for (int p = 0; p < 64; p++) begin
            exp_q.push_back(mk(1, 0, 0, 0, 1, 0, a, 8'h00, 1, 1, 0));
            exp_q.push_back(mk(1, 0, 0, 0, 1, 0, a, 8'h00, 1, 1, 0));
            exp_q.push_back(mk(1, 0, 0, 1, 1, 0, a, 8'h00, 0, 0, 0));
            dq = resp[(p < nresp) ? p : nresp - 1];
            if (dq[7] == tgt) begin
                fail = 1'b0;
                break;
            end
            if (retry || (p + 1 == POLL_LIM)) begin
                fail = 1'b1;
                break;
            end
            if (dq[5]) retry = 1'b1;
        end
        exp_q.push_back(mk(0, 1, 1, 1, 1, fail, 19'h0, 8'h00, 1, 0, 0));
        exp_err = fail;
        len = exp_q.size();
    endtask

    task automatic compare_loop();
        exp_t r;
        logic ok;
        forever begin
            @(negedge clk);
            tcyc++;
            if (exp_q.size() > 0) begin
                r  = exp_q.pop_front();
                ok = (busy === r.busy) && (done === r.done) && (f_oe_n === r.oe_n) &&
                     (f_we_n === r.we_n) && (error === r.err) &&
                     (!r.c_ce || f_ce_n === r.ce_n) && (!r.c_ad || f_addr === r.ad) &&
                     (!r.c_dt || f_dout === r.dt);
            end else begin
                r  = mk(0, 0, 1, 1, 1, exp_err, 19'h0, 8'h00, 1, 0, 0);
                ok = (busy === 1'b0) && (done === 1'b0) && (f_ce_n === 1'b1) &&
                     (f_oe_n === 1'b1) && (f_we_n === 1'b1) && (error === exp_err);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cycle %s@%0d actual busy=%b done=%b ce=%b oe=%b we=%b err=%b a=%h d=%h required busy=%b done=%b ce=%b oe=%b we=%b err=%b a=%h d=%h",
                         cur_name, tcyc, busy, done, f_ce_n, f_oe_n, f_we_n, error, f_addr, f_dout,
                         r.busy, r.done, r.ce_n, r.oe_n, r.we_n, r.err, r.ad, r.dt);
            end
        end
    endtask

    task automatic set_resp(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2,
                            input logic [7:0] r3, input int n);
        resp[0] = r0; resp[1] = r1; resp[2] = r2; resp[3] = r3;
        for (int i = 4; i < 8; i++) resp[i] = r3;
        nresp = n;
    endtask

    // Returns one tick after the accept edge with the timeline loaded and operands scrambled
    task automatic launch(input logic o, input logic [18:0] a, input logic [7:0] d, output int len);
        @(posedge clk);
        #1;
        start = 1'b1; op = o; addr = a; wdata = d;
        @(posedge clk);
        #1;
        start = 1'b0; op = ~o; addr = ~a; wdata = ~d;
        poll_base = npolls;
        wr_base   = wr_q.size();
        build(o, a, d, len);
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (exp_q.size() > 0 && i < 200) begin
            @(posedge clk);
            i++;
        end
        chk({cur_name, "_drain"}, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int len;
        reset_n = 1'b0; start = 1'b0; op = 1'b0; addr = '0; wdata = '0;
        set_resp(8'h00, 8'h00, 8'h00, 8'h00, 1);
        fork
            compare_loop();
        join_none
        #2;
        chk("reset_ctl", {busy, done, error, f_ce_n, f_oe_n, f_we_n}, 6'b000111);
        chk("reset_addr", f_addr, 0);
        chk("reset_dout", f_dout, 0);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // Program, first poll matches DQ7 = wdata[7] = 0
        cur_name = "prog";
        set_resp(8'h00, 8'h00, 8'h00, 8'h00, 2);
        launch(1'b0, 19'h12345, 8'h5A, len);
        chk("prog_len", len, 20);
        wait_drain();
        chk("prog_nwr", wr_q.size() - wr_base, 4);
        chk("prog_w0", wr_q[wr_base + 0], 32'h00555AA);
        chk("prog_w1", wr_q[wr_base + 1], 32'h002AA55);
        chk("prog_w2", wr_q[wr_base + 2], 32'h00555A0);
        chk("prog_w3", wr_q[wr_base + 3], 32'h123455A);
        chk("prog_polls", npolls - poll_base, 1);
        chk("prog_err", error, 0);

        // Erase, completes on 4th poll; start re-pulsed during polling and in FINISH
        cur_name = "erase";
        set_resp(8'h00, 8'h00, 8'h00, 8'h80, 4);
        launch(1'b1, 19'h40000, 8'h00, len);
        chk("erase_len", len, 37);
        repeat (25) @(posedge clk);
        #1 start = 1'b1; op = 1'b0; addr = 19'h7FFFF; wdata = 8'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain();
        chk("erase_nwr", wr_q.size() - wr_base, 6);
        chk("erase_w2", wr_q[wr_base + 2], 32'h0055580);
        chk("erase_w5", wr_q[wr_base + 5], 32'h4000030);
        chk("erase_polls", npolls - poll_base, 4);
        chk("erase_err", error, 0);

        // Program wdata=80h: miss, miss with DQ5, confirmation miss -> error
        cur_name = "dq5";
        set_resp(8'h00, 8'h20, 8'h20, 8'h20, 3);
        launch(1'b0, 19'h00100, 8'h80, len);
        chk("dq5_len", len, 26);
        wait_drain();
        chk("dq5_polls", npolls - poll_base, 3);
        chk("dq5_err", error, 1);
        repeat (5) @(posedge clk);
        #1 chk("dq5_err_sticky", error, 1);

        // Never completes: stops at the poll limit
        cur_name = "limit";
        set_resp(8'h80, 8'h80, 8'h80, 8'h80, 1);
        launch(1'b0, 19'h7FFFF, 8'h00, len);
        chk("limit_err_cleared", error, 0);
        chk("limit_len", len, 29);
        wait_drain();
        chk("limit_polls", npolls - poll_base, 4);
        chk("limit_err", error, 1);

        // Asynchronous reset during the 3rd write pulse
        cur_name = "abort";
        set_resp(8'h80, 8'h80, 8'h80, 8'h80, 1);
        launch(1'b0, 19'h01234, 8'hA5, len);
        repeat (9) @(posedge clk);
        #2 chk("abort_in_pulse", f_we_n, 0);
        reset_n = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        #1;
        chk("abort_we", f_we_n, 1);
        chk("abort_oe", f_oe_n, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (3) @(posedge clk);

        cur_name = "restart";
        launch(1'b0, 19'h01234, 8'hA5, len);
        chk("restart_len", len, 20);
        wait_drain();
        chk("restart_nwr", wr_q.size() - wr_base, 4);
        chk("restart_w0", wr_q[wr_base + 0], 32'h00555AA);
        chk("restart_w3", wr_q[wr_base + 3], 32'h01234A5);
        chk("restart_polls", npolls - poll_base, 1);
        chk("restart_err", error, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
